mul_arb: RTL and testbench

Two-requester arbiter and pipeline controller for the shared 32×32 signed Booth/Wallace multiplier `mul_top`. It accepts multiply requests from two independent clients over valid/ready handshakes and grants them round-robin. It registers the operands into the combinational multiplier and returns the 64-bit product, tagged with requester ID and client tag, through a single backpressurable response port. It sits between the issue logic of two execution clients and the one physical multiplier instance.

---
 rtl/mul_pkg.sv | 30 +++
 rtl/mul_rr_arb2.sv | 31 +++
 rtl/mul_top.sv | 22 ++
 rtl/mul_arb.sv | 115 +++++++++++
 tb/tb_mul_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter slice.
//   MUL_NREQ  : number of requesters sharing the multiplier
//   MUL_DW    : operand width
//   MUL_PW    : product width
//   MUL_TAG_W : default client tag width
//   s1_entry_t / s2_entry_t : stage-entry field layouts. The tag is kept
//   outside the structs so that its width can follow the module parameter.
package mul_pkg;

  localparam int MUL_NREQ  = 2;
  localparam int MUL_DW    = 32;
  localparam int MUL_PW    = 64;
  localparam int MUL_TAG_W = 4;

  // Operand register: drives the combinational multiplier.
  typedef struct packed {
    logic              valid;
    logic              id;
    logic [MUL_DW-1:0] src1;
    logic [MUL_DW-1:0] src2;
  } s1_entry_t;

  // Result register: drives the response port.
  typedef struct packed {
    logic              valid;
    logic              id;
    logic [MUL_PW-1:0] prod;
  } s2_entry_t;

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-way round-robin arbiter.
//   valid    : per-requester request valid
//   prio     : requester that wins when both are valid
//   accept   : per-requester completed handshake this cycle
//   grant    : one-hot (or zero) grant, a function of valid and prio only
//   prio_nxt : next priority; moves to the other requester only on accept
module mul_rr_arb2
  import mul_pkg::*;
(
  input  logic [MUL_NREQ-1:0] valid,
  input  logic                prio,
  input  logic [MUL_NREQ-1:0] accept,
  output logic [MUL_NREQ-1:0] grant,
  output logic                prio_nxt
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end

    prio_nxt = prio;
    if (accept[0]) begin
      prio_nxt = 1'b1;
    end else if (accept[1]) begin
      prio_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/mul_top.sv
// Shared 32x32 signed multiplier (combinational).
//   src1 : multiplicand, two's complement
//   src2 : multiplier, two's complement
//   prod : exact 64-bit signed product
module mul_top
  import mul_pkg::*;
(
  input  logic [MUL_DW-1:0] src1,
  input  logic [MUL_DW-1:0] src2,
  output logic [MUL_PW-1:0] prod
);

  logic signed [MUL_PW-1:0] a_ext;
  logic signed [MUL_PW-1:0] b_ext;

  // Sign-extend to the full product width first so the low 64 bits of the
  // multiply are the exact signed product.
  assign a_ext = {{(MUL_PW-MUL_DW){src1[MUL_DW-1]}}, src1};
  assign b_ext = {{(MUL_PW-MUL_DW){src2[MUL_DW-1]}}, src2};
  assign prod  = a_ext * b_ext;

endmodule

// File: rtl/mul_arb.sv
// Two-requester arbiter and two-stage pipeline controller for mul_top.
//   clk, resetn        : rising-edge clock, asynchronous active-low reset
//   req_valid/ready    : per-requester request handshake
//   req_src1/src2/tag  : per-requester operands and tag
//   rsp_valid/ready    : response handshake
//   rsp_prod/id/tag    : signed product, issuing requester and its tag
//   busy               : S1 or S2 holds a valid entry
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and payload stable
// until that edge; ready never depends combinationally on the consumer's own
// ready of the same port (request grant depends only on req_valid and prio).
module mul_arb
  import mul_pkg::*;
#(
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [MUL_NREQ-1:0]              req_valid,
  output logic [MUL_NREQ-1:0]              req_ready,
  input  logic [MUL_NREQ-1:0][MUL_DW-1:0]  req_src1,
  input  logic [MUL_NREQ-1:0][MUL_DW-1:0]  req_src2,
  input  logic [MUL_NREQ-1:0][TAG_W-1:0]   req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [MUL_PW-1:0]                rsp_prod,
  output logic                             rsp_id,
  output logic [TAG_W-1:0]                 rsp_tag,
  output logic                             busy
);

  s1_entry_t          s1;
  s2_entry_t          s2;
  logic [TAG_W-1:0]   s1_tag;
  logic [TAG_W-1:0]   s2_tag;
  logic               prio;
  logic               prio_nxt;
  logic [MUL_NREQ-1:0] grant;
  logic [MUL_NREQ-1:0] accept;
  logic               gid;
  logic               s1_adv;
  logic               s2_adv;
  logic [MUL_PW-1:0]  mul_prod;

  assign s2_adv = !s2.valid | rsp_ready;
  assign s1_adv = !s1.valid | s2_adv;

  // Gating with resetn keeps req_ready low while reset is held, even though
  // the empty pipeline would otherwise be ready.
  assign req_ready = grant & {MUL_NREQ{s1_adv & resetn}};
  assign accept    = req_valid & req_ready;
  assign gid       = grant[1];

  mul_rr_arb2 u_arb (
    .valid    (req_valid),
    .prio     (prio),
    .accept   (accept),
    .grant    (grant),
    .prio_nxt (prio_nxt)
  );

  mul_top u_mul (
    .src1 (s1.src1),
    .src2 (s1.src2),
    .prod (mul_prod)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio <= 1'b0;
    end else begin
      prio <= prio_nxt;
    end
  end

  // S1: loads the granted request, or empties when advancing without one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s1_tag <= '0;
    end else if (s1_adv) begin
      if (|grant) begin
        s1.valid <= 1'b1;
        s1.id    <= gid;
        s1.src1  <= req_src1[gid];
        s1.src2  <= req_src2[gid];
        s1_tag   <= req_tag[gid];
      end else begin
        s1     <= '0;
        s1_tag <= '0;
      end
    end
  end

  // S2: captures the multiplier output whenever the response slot frees up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2     <= '0;
      s2_tag <= '0;
    end else if (s2_adv) begin
      s2.valid <= s1.valid;
      s2.id    <= s1.id;
      s2.prod  <= mul_prod;
      s2_tag   <= s1_tag;
    end
  end

  assign rsp_valid = s2.valid;
  assign rsp_prod  = s2.prod;
  assign rsp_id    = s2.id;
  assign rsp_tag   = s2_tag;
  assign busy      = s1.valid | s2.valid;

endmodule

// File: tb/tb_mul_arb.sv
// Directed self-checking bench for mul_arb.
module tb_mul_arb;

  localparam int TAG_W = 4;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b1;
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][31:0]        req_src1;
  logic [1:0][31:0]        req_src2;
  logic [1:0][TAG_W-1:0]   req_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [63:0]             rsp_prod;
  logic                    rsp_id;
  logic [TAG_W-1:0]        rsp_tag;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mul_arb #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    req_tag   = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
    req_valid[i] = 1'b1;
    req_src1[i]  = a;
    req_src2[i]  = b;
    req_tag[i]   = t;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_src1[0] = 32'd5;
    req_src2[0] = 32'd5;
    #1 resetn = 1'b0;
    #2;
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_ctl: got %b, expected 0", {rsp_valid, rsp_id, rsp_tag});
    end
    checks++;
    if (rsp_prod !== 64'd0) begin
      errors++;
      $display("FAIL reset_rsp_prod: got %h, expected 0", rsp_prod);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready: got %b, expected 00", req_ready);
    end
    tick();
    tick();
    checks++;
    if ({req_ready, busy, rsp_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: got %b, expected 0000", {req_ready, busy, rsp_valid});
    end
    resetn = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(0, 32'd3, 32'hFFFF_FFFB, 4'd2);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b, expected 01", req_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_cycle1: got valid,busy=%b, expected 01", {rsp_valid, busy});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b0, 4'd2, 64'hFFFF_FFFF_FFFF_FFF1}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%b tag=%0d prod=%h, expected v=1 id=0 tag=2 prod=fffffffffffffff1",
               rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_drain: got valid,busy=%b, expected 00", {rsp_valid, busy});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    set_req(0, 32'd5, 32'd7, 4'd1);
    set_req(1, 32'd6, 32'd6, 4'd9);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL simul_first: got %b, expected 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL simul_second: got %b, expected 10", req_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b0, 4'd1, 64'd35}) begin
      errors++;
      $display("FAIL simul_rsp0: got v=%b id=%b tag=%0d prod=%0d, expected v=1 id=0 tag=1 prod=35",
               rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b1, 4'd9, 64'd36}) begin
      errors++;
      $display("FAIL simul_rsp1: got v=%b id=%b tag=%0d prod=%0d, expected v=1 id=1 tag=9 prod=36",
               rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain: got %b, expected 0", rsp_valid);
    end
    // Priority must be back on requester 0: probe with both valid, then
    // withdraw before the edge.
    set_req(0, 32'd1, 32'd1, 4'd0);
    set_req(1, 32'd1, 32'd1, 4'd0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL simul_prio_back: got %b, expected 01", req_ready);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_streaming();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k < 4) begin
        set_req(1, 32'(k + 1), 32'h10, TAG_W'(k));
        exp_q.push_back(64'((k + 1) * 16));
      end
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (req_ready !== 2'b10) begin
          errors++;
          $display("FAIL stream_ready[%0d]: got %b, expected 10", k, req_ready);
        end
      end
      if (k >= 2) begin
        logic [63:0] exp_p;
        exp_p = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b1, TAG_W'(k - 2), exp_p}) begin
          errors++;
          $display("FAIL stream_rsp[%0d]: got v=%b id=%b tag=%0d prod=%h, expected v=1 id=1 tag=%0d prod=%h",
                   k, rsp_valid, rsp_id, rsp_tag, rsp_prod, k - 2, exp_p);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stream_drain: got %b, expected 00", {rsp_valid, busy});
    end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    idle_inputs();
    set_req(0, 32'd2, 32'd3, 4'd3);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_fill_a: got %b, expected 01", req_ready);
    end
    tick();
    idle_inputs();
    set_req(1, 32'd4, 32'd5, 4'd4);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_fill_b: got %b, expected 10", req_ready);
    end
    tick();
    idle_inputs();
    set_req(0, 32'd7, 32'd8, 4'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, busy, rsp_valid, rsp_id, rsp_tag, rsp_prod} !==
          {2'b00, 1'b1, 1'b1, 1'b0, 4'd3, 64'd6}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b busy=%b v=%b id=%b tag=%0d prod=%0d, expected rdy=00 busy=1 v=1 id=0 tag=3 prod=6",
                 c, req_ready, busy, rsp_valid, rsp_id, rsp_tag, rsp_prod);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {2'b01, 1'b1, 1'b0, 4'd3, 64'd6}) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b id=%b tag=%0d prod=%0d, expected rdy=01 v=1 id=0 tag=3 prod=6",
               req_ready, rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b1, 4'd4, 64'd20}) begin
      errors++;
      $display("FAIL bp_rsp_b: got v=%b id=%b tag=%0d prod=%0d, expected v=1 id=1 tag=4 prod=20",
               rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b0, 4'd5, 64'd56}) begin
      errors++;
      $display("FAIL bp_rsp_c: got v=%b id=%b tag=%0d prod=%0d, expected v=1 id=0 tag=5 prod=56",
               rsp_valid, rsp_id, rsp_tag, rsp_prod);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drain: got %b, expected 00", {rsp_valid, busy});
    end
    tick();
  endtask

  task automatic test_corners();
    logic [31:0] a_tab [4];
    logic [31:0] b_tab [4];
    logic [63:0] p_tab [4];
    a_tab = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    b_tab = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    p_tab = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
              64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000};
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k < 4) begin
        set_req(0, a_tab[k], b_tab[k], TAG_W'(k));
        exp_q.push_back(p_tab[k]);
      end
      @(negedge clk);
      if (k >= 2) begin
        logic [63:0] exp_p;
        exp_p = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_prod} !== {1'b1, 1'b0, TAG_W'(k - 2), exp_p}) begin
          errors++;
          $display("FAIL corner_rsp[%0d]: got v=%b id=%b tag=%0d prod=%h, expected v=1 id=0 tag=%0d prod=%h",
                   k - 2, rsp_valid, rsp_id, rsp_tag, rsp_prod, k - 2, exp_p);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    idle_inputs();
    set_req(1, 32'd9, 32'd9, 4'd7);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL ar_fill_1: got %b, expected 10", req_ready);
    end
    tick();
    idle_inputs();
    set_req(0, 32'd3, 32'd3, 4'd8);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL ar_fill_0: got %b, expected 01", req_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL ar_full: got %b, expected 11", {rsp_valid, busy});
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL ar_immediate: got v,busy,rdy=%b, expected 0000", {rsp_valid, busy, req_ready});
    end
    #1 resetn = 1'b1;
    rsp_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL ar_no_rsp[%0d]: got %b, expected 00", c, {rsp_valid, busy});
      end
      tick();
    end
    set_req(0, 32'd1, 32'd2, 4'd0);
    set_req(1, 32'd3, 32'd4, 4'd1);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL ar_prio_reset: got %b, expected 01", req_ready);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    idle_inputs();
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_streaming();
    test_backpressure();
    test_corners();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
